// File: rtl/random_state_generator_mc_if.sv
// Control and observation bundle for random_state_generator_mc.
// The generator sits on the slave side; whoever drives the ranges and enables is the master.
interface random_state_generator_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned LFSR_W = 32
);
  logic [NUM_CH-1:0] en_i;
  logic              mode_i;
  logic [CNT_W-1:0]  lo_min_i;
  logic [CNT_W-1:0]  lo_max_i;
  logic [CNT_W-1:0]  hi_min_i;
  logic [CNT_W-1:0]  hi_max_i;
  logic [LFSR_W-1:0] seed_i;
  logic              seed_load_i;
  logic [NUM_CH-1:0] state_o;
  logic [NUM_CH-1:0] toggle_o;
  logic              cfg_err_o;

  modport master (
    output en_i, mode_i, lo_min_i, lo_max_i, hi_min_i, hi_max_i, seed_i, seed_load_i,
    input  state_o, toggle_o, cfg_err_o
  );

  modport slave (
    input  en_i, mode_i, lo_min_i, lo_max_i, hi_min_i, hi_max_i, seed_i, seed_load_i,
    output state_o, toggle_o, cfg_err_o
  );
endinterface

// File: rtl/random_state_generator_mc.sv
// Multi-channel random dwell generator: each channel alternates low/high levels whose
// lengths are drawn from a per-channel Galois LFSR and scaled into a [min, max] window.
module random_state_generator_mc #(
  parameter int unsigned       NUM_CH   = 4,
  parameter int unsigned       CNT_W    = 16,
  parameter int unsigned       LFSR_W   = 32,
  parameter logic [LFSR_W-1:0] SEED_DEF = 32'hACE1_2468
) (
  input logic                        clk_i,
  input logic                        a_rst_i,
  random_state_generator_mc_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [LFSR_W-1:0] Taps     = LFSR_W'(32'h8020_0003);
  localparam logic [LFSR_W-1:0] ChStride = LFSR_W'(32'h9E37_79B9);

  function automatic logic [LFSR_W-1:0] mix_seed(input logic [LFSR_W-1:0] seed,
                                                 input int unsigned       ch);
    logic [LFSR_W-1:0] m;
    m = seed ^ (LFSR_W'(ch) * ChStride);
    return (m == '0) ? LFSR_W'(1) : m;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? Taps : '0);
  endfunction

  // min of 0 behaves as 1; an inverted window collapses to min.
  function automatic logic [CNT_W-1:0] draw_limit(input logic [CNT_W-1:0] min_v,
                                                  input logic [CNT_W-1:0] max_v,
                                                  input logic [CNT_W-1:0] rnd,
                                                  input logic             fixed);
    logic [CNT_W-1:0]   min_eff;
    logic [CNT_W-1:0]   span;
    logic [CNT_W:0]     span1;
    logic [2*CNT_W:0]   prod;
    min_eff = (min_v == '0) ? CNT_W'(1) : min_v;
    span    = (max_v > min_eff) ? (max_v - min_eff) : '0;
    span1   = {1'b0, span} + (CNT_W+1)'(1);
    prod    = {{(CNT_W+1){1'b0}}, rnd} * {{CNT_W{1'b0}}, span1};
    if (fixed) begin
      return min_eff;
    end
    return min_eff + CNT_W'(prod >> CNT_W);
  endfunction

  logic [1:0]        st_q   [NUM_CH];
  logic [1:0]        st_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  lim_q  [NUM_CH];
  logic [CNT_W-1:0]  lim_d  [NUM_CH];
  logic [LFSR_W-1:0] lfsr_q [NUM_CH];
  logic [LFSR_W-1:0] lfsr_d [NUM_CH];
  logic [CNT_W-1:0]  lo_lim [NUM_CH];
  logic [CNT_W-1:0]  hi_lim [NUM_CH];
  logic [NUM_CH-1:0] state_q, state_d;
  logic [NUM_CH-1:0] toggle_q, toggle_d;
  logic [NUM_CH-1:0] draw;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    draw     = '0;
    state_d  = state_q;
    toggle_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      st_d[c]   = st_q[c];
      cnt_d[c]  = cnt_q[c];
      lim_d[c]  = lim_q[c];
      lo_lim[c] = draw_limit(bus.lo_min_i, bus.lo_max_i, lfsr_q[c][CNT_W-1:0], bus.mode_i);
      hi_lim[c] = draw_limit(bus.hi_min_i, bus.hi_max_i, lfsr_q[c][CNT_W-1:0], bus.mode_i);

      case (st_q[c])
        StIdle: begin
          if (bus.en_i[c]) begin
            st_d[c]  = StLow;
            lim_d[c] = lo_lim[c];
            cnt_d[c] = '0;
            draw[c]  = 1'b1;
          end
        end
        StLow, StHigh: begin
          if (!bus.en_i[c]) begin
            st_d[c]     = StIdle;
            cnt_d[c]    = '0;
            state_d[c]  = 1'b0;
            toggle_d[c] = state_q[c];
          end else if (cnt_q[c] == lim_q[c] - CNT_W'(1)) begin
            st_d[c]     = (st_q[c] == StLow) ? StHigh : StLow;
            lim_d[c]    = (st_q[c] == StLow) ? hi_lim[c] : lo_lim[c];
            cnt_d[c]    = '0;
            state_d[c]  = (st_q[c] == StLow);
            toggle_d[c] = 1'b1;
            draw[c]     = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        default: begin
          st_d[c]    = StIdle;
          cnt_d[c]   = '0;
          state_d[c] = 1'b0;
        end
      endcase

      // A reload wins over a same-cycle draw; the draw already consumed the old value.
      if (bus.seed_load_i) begin
        lfsr_d[c] = mix_seed(bus.seed_i, c);
      end else if (draw[c]) begin
        lfsr_d[c] = lfsr_step(lfsr_q[c]);
      end else begin
        lfsr_d[c] = lfsr_q[c];
      end
    end

    // Raw compare: min == 0 with max == 0 is a legal one-cycle window.
    cfg_err_d = (bus.lo_min_i > bus.lo_max_i) | (bus.hi_min_i > bus.hi_max_i);
  end

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= StIdle;
        cnt_q[c]  <= '0;
        lim_q[c]  <= '0;
        lfsr_q[c] <= mix_seed(SEED_DEF, c);
      end
      state_q   <= '0;
      toggle_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= st_d[c];
        cnt_q[c]  <= cnt_d[c];
        lim_q[c]  <= lim_d[c];
        lfsr_q[c] <= lfsr_d[c];
      end
      state_q   <= state_d;
      toggle_q  <= toggle_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.state_o   = state_q;
  assign bus.toggle_o  = toggle_q;
  assign bus.cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_random_state_generator_mc.sv
// Directed bench for random_state_generator_mc; expected dwell lengths are worked out by hand
// from the reset seeds, the LFSR polynomial and the scaling rule.
module tb_random_state_generator_mc;

  logic clk_i = 1'b0;
  logic a_rst_i;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk_i = ~clk_i;

  random_state_generator_mc_if #(.NUM_CH(4), .CNT_W(16), .LFSR_W(32)) bus ();

  random_state_generator_mc #(
    .NUM_CH  (4),
    .CNT_W   (16),
    .LFSR_W  (32),
    .SEED_DEF(32'hACE1_2468)
  ) dut (
    .clk_i  (clk_i),
    .a_rst_i(a_rst_i),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Cycles until the channel's next toggle pulse, bounded.
  task automatic run_len(input int ch, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.toggle_o[ch] !== 1'b1 && n < 500);
  endtask

  task automatic set_ranges(input logic [15:0] lmin, input logic [15:0] lmax,
                            input logic [15:0] hmin, input logic [15:0] hmax,
                            input logic        mode);
    bus.lo_min_i = lmin;
    bus.lo_max_i = lmax;
    bus.hi_min_i = hmin;
    bus.hi_max_i = hmax;
    bus.mode_i   = mode;
  endtask

  task automatic apply_reset();
    a_rst_i         = 1'b1;
    bus.en_i        = '0;
    bus.seed_load_i = 1'b0;
    tick();
    tick();
    a_rst_i = 1'b0;
  endtask

  initial begin
    int n;
    bus.seed_i = '0;
    set_ranges(16'd3, 16'd3, 16'd5, 16'd5, 1'b1);
    apply_reset();
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_toggle", 32'(bus.toggle_o), 32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err_o), 32'd0);

    // Fixed dwell: 3+1 low, then 5 high, 3 low, 5 high.
    bus.en_i = 4'hF;
    run_len(0, n);
    check("fix_first_low", n, 32'd4);
    check("fix_rise_state", 32'(bus.state_o), 32'hF);
    check("fix_rise_toggle", 32'(bus.toggle_o), 32'hF);
    run_len(0, n);
    check("fix_high", n, 32'd5);
    check("fix_fall_state", 32'(bus.state_o), 32'd0);
    run_len(0, n);
    check("fix_low", n, 32'd3);
    run_len(0, n);
    check("fix_high2", n, 32'd5);

    // Random dwell, ch0 seed 0xACE12468: limits 11, 36, 13.
    set_ranges(16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
    apply_reset();
    bus.en_i = 4'b0001;
    run_len(0, n);
    check("rnd_ch0_low1", n, 32'd12);
    run_len(0, n);
    check("rnd_ch0_high1", n, 32'd36);
    run_len(0, n);
    check("rnd_ch0_low2", n, 32'd13);

    // ch1 seed 0x32D65DD1: first low limit 14.
    apply_reset();
    bus.en_i = 4'b0010;
    run_len(1, n);
    check("rnd_ch1_low1", n, 32'd15);

    // Inverted low window: dwell collapses to min, error flag follows.
    set_ranges(16'd8, 16'd4, 16'd5, 16'd5, 1'b0);
    apply_reset();
    bus.en_i = 4'b0001;
    tick();
    check("err_set", 32'(bus.cfg_err_o), 32'd1);
    run_len(0, n);
    check("err_low_dwell", n, 32'd8);
    set_ranges(16'd4, 16'd8, 16'd5, 16'd5, 1'b0);
    tick();
    check("err_clear", 32'(bus.cfg_err_o), 32'd0);

    // Zero minimum behaves as one: toggles every cycle after the first low.
    set_ranges(16'd0, 16'd0, 16'd1, 16'd1, 1'b0);
    apply_reset();
    bus.en_i = 4'b0001;
    run_len(0, n);
    check("min0_first", n, 32'd2);
    run_len(0, n);
    check("min0_high", n, 32'd1);
    run_len(0, n);
    check("min0_low", n, 32'd1);
    check("min0_cfg_err", 32'(bus.cfg_err_o), 32'd0);

    // Drop en[2] mid-high, then re-enable.
    set_ranges(16'd3, 16'd3, 16'd5, 16'd5, 1'b1);
    apply_reset();
    bus.en_i = 4'hF;
    run_len(2, n);
    check("drop_first_low", n, 32'd4);
    tick();
    tick();
    bus.en_i = 4'b1011;
    tick();
    check("drop_state", 32'(bus.state_o), 32'b1011);
    check("drop_toggle", 32'(bus.toggle_o), 32'b0100);
    bus.en_i = 4'hF;
    run_len(2, n);
    check("reen_low", n, 32'd4);

    // Reload with seed 0 alongside the first draw: draw uses old value, LFSR becomes 1.
    set_ranges(16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
    apply_reset();
    bus.seed_i      = '0;
    bus.seed_load_i = 1'b1;
    bus.en_i        = 4'b0001;
    tick();
    bus.seed_load_i = 1'b0;
    run_len(0, n);
    check("seed_low1", n, 32'd11);
    run_len(0, n);
    check("seed_high1", n, 32'd30);
    run_len(0, n);
    check("seed_low2", n, 32'd10);

    // Async reset in the middle of a high level.
    set_ranges(16'd3, 16'd3, 16'd5, 16'd5, 1'b1);
    apply_reset();
    bus.en_i = 4'hF;
    run_len(0, n);
    check("ar_high_state", 32'(bus.state_o), 32'hF);
    #2;
    a_rst_i = 1'b1;
    #1;
    check("ar_state", 32'(bus.state_o), 32'd0);
    check("ar_toggle", 32'(bus.toggle_o), 32'd0);
    tick();
    a_rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
